// File: rtl/sub16_pipe.sv
// Two-stage pipelined 16-bit subtractor, d = a - b - bin, built from 4-bit
// borrow-lookahead groups. The low byte resolves in stage 1; the high byte and the flags resolve in stage 2.
module sub16_pipe #(
  parameter int PIPE_BYPASS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] d,
  output logic        bout,
  output logic        zero,
  output logic        ovf
);

  // Only the two-stage pipeline exists; refuse to elaborate any other setting.
  if (PIPE_BYPASS != 0) begin : g_bad_param
    $error("sub16_pipe: PIPE_BYPASS must be 0");
  end

  typedef struct packed {
    logic [3:0] d;
    logic       g;
    logic       p;
  } grp_t;

  // One 4-bit borrow-lookahead group with flat borrow equations and group G/P.
  function automatic grp_t bla4(input logic [3:0] x, input logic [3:0] y,
                                input logic br_in);
    logic [3:0] p, g, br;
    grp_t       r;
    p     = ~(x ^ y);
    g     = ~x & y;
    br[0] = br_in;
    br[1] = g[0] | (p[0] & br_in);
    br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br_in);
    br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & br_in);
    r.d   = x ^ y ^ br;
    r.g   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.p   = &p;
    return r;
  endfunction

  logic        s1_valid;
  logic [7:0]  s1_dlo;
  logic        s1_br8;
  logic [7:0]  s1_ahi;
  logic [7:0]  s1_bhi;
  logic        s2_valid;

  logic        s2_free, s1_adv, accept;
  grp_t        grp0, grp1, grp2, grp3;
  logic        br4, br8, br12, br16;
  logic [15:0] d_next;

  assign s2_free   = ~s2_valid | out_ready;
  assign s1_adv    = s1_valid & s2_free;
  assign in_ready  = ~s1_valid | s1_adv;
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid;

  // Stage 1: low byte, second-level lookahead across groups 0 and 1.
  assign grp0 = bla4(a[3:0], b[3:0], bin);
  assign br4  = grp0.g | (grp0.p & bin);
  assign grp1 = bla4(a[7:4], b[7:4], br4);
  assign br8  = grp1.g | (grp1.p & grp0.g) | (grp1.p & grp0.p & bin);

  // Stage 2: high byte from the registered operands and the stage-1 borrow.
  assign grp2   = bla4(s1_ahi[3:0], s1_bhi[3:0], s1_br8);
  assign br12   = grp2.g | (grp2.p & s1_br8);
  assign grp3   = bla4(s1_ahi[7:4], s1_bhi[7:4], br12);
  assign br16   = grp3.g | (grp3.p & grp2.g) | (grp3.p & grp2.p & s1_br8);
  assign d_next = {grp3.d, grp2.d, s1_dlo};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dlo   <= '0;
      s1_br8   <= 1'b0;
      s1_ahi   <= '0;
      s1_bhi   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_dlo   <= {grp1.d, grp0.d};
      s1_br8   <= br8;
      s1_ahi   <= a[15:8];
      s1_bhi   <= b[15:8];
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Output register holds its data through a stall; only valid drops on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      d        <= '0;
      bout     <= 1'b0;
      zero     <= 1'b0;
      ovf      <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      d        <= d_next;
      bout     <= br16;
      zero     <= (d_next == 16'h0000);
      ovf      <= (s1_ahi[7] ^ s1_bhi[7]) & (d_next[15] ^ s1_ahi[7]);
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sub16_pipe.sv
// Self-checking bench for sub16_pipe: directed vectors, stalled stream,
// asynchronous reset mid-flight and a random handshake run against a scoreboard.
module tb_sub16_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, d;
  logic        bin, bout, zero, ovf;

  int checks   = 0;
  int failures = 0;

  logic [18:0] exp_q[$];
  logic        prev_stall;
  logic [18:0] prev_out;
  logic        saw_ready_low;

  sub16_pipe #(.PIPE_BYPASS(0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {d, bout, zero, ovf} for a - b - bin modulo 2^16.
  function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mbin);
    logic [16:0] r;
    logic        v;
    r = {1'b0, ma} - {1'b0, mb} - {16'h0000, mbin};
    v = (ma[15] ^ mb[15]) & (r[15] ^ ma[15]);
    return {r[15:0], r[16], (r[15:0] == 16'h0000), v};
  endfunction

  task automatic run_one(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                         input logic [18:0] exp);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("dir_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; bin = 1'b1;
    check("dir_lat1_valid", out_valid, 0);
    @(posedge clk); #1;
    check("dir_lat2_valid", out_valid, 1);
    check("dir_result", {d, bout, zero, ovf}, exp);
    @(posedge clk); #1;
    check("dir_drained", out_valid, 0);
  endtask

  // One clock of the scoreboard: inputs were set at posedge+1, checked at posedge+2.
  task automatic cycle();
    #1;
    check("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
    if (!in_ready) saw_ready_low = 1'b1;
    if (prev_stall) begin
      check("stall_valid", out_valid, 1);
      check("stall_hold", {d, bout, zero, ovf}, prev_out);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 1, 0);
      else check("sb_result", {d, bout, zero, ovf}, exp_q.pop_front());
    end
    if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
    prev_stall = out_valid & ~out_ready;
    prev_out   = {d, bout, zero, ovf};
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int budget;
    in_valid = 1'b0; out_ready = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      cycle();
      budget++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  logic [15:0] s_a[8]   = '{16'h0000, 16'h8000, 16'h1235, 16'h00FF, 16'hFFFF, 16'h1000, 16'h7FFF, 16'hABCD};
  logic [15:0] s_b[8]   = '{16'h0001, 16'h0001, 16'h1234, 16'h00FF, 16'hFFFF, 16'h0FFF, 16'hFFFF, 16'h1234};
  logic        s_bin[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int sent, cyc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    prev_stall = 1'b0; prev_out = '0; saw_ready_low = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_flags", {d, bout, zero, ovf}, 19'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    run_one(16'h0000, 16'h0001, 1'b0, {16'hFFFF, 1'b1, 1'b0, 1'b0});
    run_one(16'h8000, 16'h0001, 1'b0, {16'h7FFF, 1'b0, 1'b0, 1'b1});
    run_one(16'h7FFF, 16'hFFFF, 1'b0, {16'h8000, 1'b1, 1'b0, 1'b1});
    run_one(16'h1235, 16'h1234, 1'b1, {16'h0000, 1'b0, 1'b1, 1'b0});
    run_one(16'h00FF, 16'h00FF, 1'b1, {16'hFFFF, 1'b1, 1'b0, 1'b0});

    // Back-to-back stream with a three-cycle output stall.
    sent = 0; cyc = 0; saw_ready_low = 1'b0; prev_stall = 1'b0;
    while ((sent < 8 || exp_q.size() != 0) && cyc < 40) begin
      in_valid  = (sent < 8);
      a         = s_a[sent % 8];
      b         = s_b[sent % 8];
      bin       = s_bin[sent % 8];
      out_ready = !(cyc >= 3 && cyc < 6);
      #1;
      if (in_valid && in_ready) sent++;
      #0;
      // cycle() re-samples the same settled values; undo the #1 already spent.
      begin
        check("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
        if (!in_ready) saw_ready_low = 1'b1;
        if (prev_stall) begin
          check("stall_valid", out_valid, 1);
          check("stall_hold", {d, bout, zero, ovf}, prev_out);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_out", 1, 0);
          else check("stream_result", {d, bout, zero, ovf}, exp_q.pop_front());
        end
        if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
        prev_stall = out_valid & ~out_ready;
        prev_out   = {d, bout, zero, ovf};
        @(posedge clk); #1;
      end
      cyc++;
    end
    check("stream_all_sent", sent, 8);
    check("stream_queue_empty", exp_q.size(), 0);
    check("stream_ready_dropped", saw_ready_low, 1);

    // Two transactions in flight, then asynchronous reset mid-cycle.
    prev_stall = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0; a = 16'h4321; b = 16'h1234; bin = 1'b0;
    @(posedge clk); #1;
    a = 16'h0005; b = 16'h0003;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_full_valid", out_valid, 1);
    check("pre_rst_full_ready", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_d", d, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("post_rst_quiet", out_valid, 0);
      @(posedge clk); #1;
    end

    // Random handshake run.
    prev_stall = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      bin       = 1'($urandom);
      cycle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
